// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter: modulus range, wrap or saturate at the boundaries,
// cycle prescaler, synchronous clear/load and a registered boundary strobe.
module mod_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf
);

    // One-bit prescaler when PRESCALE=1; it then sits at 0 and every enabled cycle steps.
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre;
    logic [PW-1:0]    pre_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;
    logic             step;

    assign step   = en && (pre == PRE_LAST);
    assign at_max = (count == MAX_VAL);
    assign at_min = (count == '0);

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        pre_nxt   = pre;
        count_nxt = count;
        ovf_nxt   = 1'b0;
        if (clear) begin
            pre_nxt   = '0;
            count_nxt = '0;
        end else if (load) begin
            pre_nxt   = '0;
            count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            pre_nxt = step ? '0 : pre + PW'(1);
            if (step) begin
                if (up) begin
                    if (at_max) begin
                        ovf_nxt = 1'b1;
                        if (SATURATE == 0) count_nxt = '0;
                    end else begin
                        count_nxt = count + WIDTH'(1);
                    end
                end else begin
                    if (at_min) begin
                        ovf_nxt = 1'b1;
                        if (SATURATE == 0) count_nxt = MAX_VAL;
                    end else begin
                        count_nxt = count - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            count <= '0;
            pre   <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            pre   <= pre_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule
